// File: rtl/weight_class_counter_if.sv
// Pixel-beat stream in, per-class count bundle out, for one digit's counter.
// The slave modport is the counter's view of the bus.
interface weight_class_counter_if #(
  parameter int NUM_CLASSES = 13,
  parameter int CNT_W       = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_active;
  logic [3:0]       in_code;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_val [0:NUM_CLASSES-1];
  logic             out_overflow;
  logic             out_frame_err;

  modport master (
    output in_valid, in_active, in_code, in_last, out_ready,
    input  in_ready, out_valid, out_val, out_overflow, out_frame_err
  );

  modport slave (
    input  in_valid, in_active, in_code, in_last, out_ready,
    output in_ready, out_valid, out_val, out_overflow, out_frame_err
  );
endinterface

// File: rtl/weight_class_counter.sv
// Counts active pixels per weight class over one frame, then holds the
// saturating counts plus overflow/framing flags behind a valid/ready handshake.
module weight_class_counter #(
  parameter int NUM_CLASSES = 13,
  parameter int CNT_W       = 8,
  parameter int FRAME_LEN   = 784
) (
  input  logic                   clk,
  input  logic                   rst,
  weight_class_counter_if.slave  bus
);
  // state | meaning
  // ACCUM | accepting pixel beats and counting per class
  // DONE  | frame closed, counts presented until the output handshake

  localparam int               IDX_W    = $clog2(FRAME_LEN) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [4:0]       CODE_LIM = 5'(NUM_CLASSES);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ready_q;
  logic [CNT_W-1:0] cnt [0:NUM_CLASSES-1];
  logic             ovf;
  logic             err;
  logic [IDX_W-1:0] beat_idx;
  logic             beat_acc;
  logic             out_fire;
  logic             hit;

  assign beat_acc = bus.in_valid && ready_q;
  assign out_fire = (state == DONE) && bus.out_ready;
  assign hit      = beat_acc && bus.in_active && ({1'b0, bus.in_code} < CODE_LIM);

  // ready is registered from the next state so it stays low through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ACCUM);
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    case (state)
      ACCUM: begin
        if (beat_acc && bus.in_last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || out_fire) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      beat_idx <= '0;
    end else if (beat_acc) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (hit && (bus.in_code == 4'(i))) begin
          if (cnt[i] == '1) ovf <= 1'b1;
          else              cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      if (beat_idx != '1) beat_idx <= beat_idx + IDX_W'(1);
      if (bus.in_last && (beat_idx != IDX_LAST)) err <= 1'b1;
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.out_val       = cnt;
  assign bus.out_overflow  = ovf;
  assign bus.out_frame_err = err;
endmodule

// File: doc/weight_class_counter.md
# weight_class_counter

Streaming front end of the per-digit scoring path. It consumes one binarised pixel per beat, paired with that pixel's 4-bit quantised weight-class code, and counts active pixels per weight class over a frame. At frame end it presents the 13 class counts, in the 8-bit array form the score adder consumes, behind a valid/ready handshake. One instance serves one output digit.

## Interface
Parameters:
- NUM_CLASSES, 13, number of weight classes counted (codes 0..NUM_CLASSES-1)
- CNT_W, 8, width of each class counter
- FRAME_LEN, 784, expected beats per frame (28x28 pixels)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_active  in  1  binarised pixel (1 = counts)
- in_code  in  4  weight-class code of this pixel
- in_last  in  1  final beat of frame
- out_valid  out  1  counts valid
- out_ready  in  1  consumer accepts counts
- out_val  out  CNT_W x [0:NUM_CLASSES-1]  per-class counts, unpacked array
- out_overflow  out  1  any class counter saturated this frame
- out_frame_err  out  1  in_last not on beat FRAME_LEN-1

## Operation
- States: ACCUM, DONE.
- Input acceptance: a beat is accepted when in_valid && in_ready.
- In ACCUM, in_ready=1 and out_valid=0. In DONE, in_ready=0 and out_valid=1.
- Accepted beat with in_active=1 and in_code<NUM_CLASSES: cnt[in_code] increments by 1.
  - Saturates at 2^CNT_W-1 (255). An increment attempted at 255 sets sticky ovf.
- Codes NUM_CLASSES..15 (13,14,15 = zero-weight pixels) and beats with in_active=0 change no counter. They still advance the beat index.
- Beat index: counts accepted beats from 0. Width clog2(FRAME_LEN)+1; saturates at all-ones.
- Accepted beat with in_last=1:
  - The beat is counted normally, then the state goes to DONE.
  - Sticky err is set if beat index != FRAME_LEN-1 (early or late last).
- out_val=cnt, out_overflow=ovf, out_frame_err=err, driven straight from registers. Outputs hold stable throughout DONE.
- Output handshake (out_valid && out_ready) in DONE: all cnt, ovf, err and the beat index clear to 0; state returns to ACCUM.
- in_valid is ignored in DONE; no beat is consumed.
- in_ready depends on state only; there is no combinational path from out_ready or any input to in_ready.

## Timing
- Reset (rst high at a clk edge): state=ACCUM, all cnt=0, ovf=0, err=0, beat index=0, out_valid=0.
- in_ready=0 while rst is high; it is 1 from the first cycle after rst deasserts.
- Reset mid-frame or in DONE discards all partial counts and any pending output. No handshake completes in the reset cycle.
- Throughput: 1 beat/cycle in ACCUM.
- Latency: last beat accepted at edge N; out_valid=1 and counts final from cycle N+1.
- Handshake accepted at edge M; in_ready=1 and counters=0 from cycle M+1. This gives a minimum of 1 bubble cycle between frames.
- The increment on the last beat is visible in out_val in the same cycle out_valid rises.
- Saturation holds at 255 for the rest of the frame; other classes keep counting.

## Test plan
- Directed frame, 784 beats, out_ready=1:
  - Stimulus: beats 0-2 active code 0; beats 3-7 active code 12; beat 8 active code 6; rest inactive; last on beat 783.
  - Response: val[0]=3, val[6]=1, val[12]=5, all other classes 0, overflow=0, frame_err=0, out_valid one cycle after last.
- Saturation: 300 active beats code 5 within a 784-beat frame -> val[5]=255, overflow=1, all other classes 0.
- Ignored codes: 784 active beats cycling codes 13, 14, 15 -> all val=0, overflow=0, frame_err=0.
- Framing error:
  - in_last on beat 99 with 100 active beats of code 1 -> val[1]=100, frame_err=1.
  - Next frame of correct length -> frame_err=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid rises while driving in_valid=1 with active code 2.
  - Response: out_val stable, in_ready=0, nothing counted. After the handshake, the next frame starts from zero counts, with in_ready rising exactly one cycle later.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle after 400 beats, then send a clean frame of 10 active code-3 beats among 784.
  - Response: val[3]=10, no stale counts, no spurious out_valid.
